// File: rtl/router_pkg.sv
// Shared definitions for the 1x3 router: output-port address codes, default byte
// width, the router FSM state encoding and small header-decode helpers.
package router_pkg;

    localparam int DATA_WIDTH = 8;

    localparam logic [1:0] ADDR_OUT0    = 2'b00;
    localparam logic [1:0] ADDR_OUT1    = 2'b01;
    localparam logic [1:0] ADDR_OUT2    = 2'b10;
    localparam logic [1:0] ADDR_INVALID = 2'b11;

    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        LOAD_PARITY        = 3'd3,
        FIFO_FULL_STATE    = 3'd4,
        LOAD_AFTER_FULL    = 3'd5,
        WAIT_TILL_EMPTY    = 3'd6,
        CHECK_PARITY_ERROR = 3'd7
    } fsm_state_t;

    function automatic logic addr_is_valid(input logic [1:0] addr);
        return (addr != ADDR_INVALID);
    endfunction

endpackage

// File: rtl/router_reg_if.sv
// Strobe/data bundle between the router FSM/source side (master) and the
// router_reg datapath stage (slave).
interface router_reg_if import router_pkg::*; #(
    parameter int DATA_WIDTH = router_pkg::DATA_WIDTH
);
    logic                  pkt_valid;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  fifo_full;
    logic                  detect_add;
    logic                  lfd_state;
    logic                  ld_state;
    logic                  laf_state;
    logic                  full_state;
    logic                  rst_int_reg;
    logic                  parity_done;
    logic                  low_packet_valid;
    logic                  err;
    logic [DATA_WIDTH-1:0] dout;

    modport master (
        output pkt_valid, data_in, fifo_full,
        output detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
        input  parity_done, low_packet_valid, err, dout
    );

    modport slave (
        input  pkt_valid, data_in, fifo_full,
        input  detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
        output parity_done, low_packet_valid, err, dout
    );
endinterface

// File: rtl/router_parity_acc.sv
// Running XOR parity over header and payload, capture of the packet parity byte,
// and the registered mismatch flag evaluated in CHECK_PARITY_ERROR.
module router_parity_acc import router_pkg::*; #(
    parameter int DATA_WIDTH = router_pkg::DATA_WIDTH
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  detect_add,
    input  logic                  lfd_state,
    input  logic                  ld_state,
    input  logic                  laf_state,
    input  logic                  rst_int_reg,
    input  logic                  pkt_valid,
    input  logic                  fifo_full,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [DATA_WIDTH-1:0] header,
    input  logic [DATA_WIDTH-1:0] hold,
    input  logic                  hold_is_par,
    output logic                  parity_done,
    output logic                  err
);

    localparam logic [DATA_WIDTH-1:0] ZERO_BYTE = {DATA_WIDTH{1'b0}};

    function automatic logic [DATA_WIDTH-1:0] parity_fold(
        input logic [DATA_WIDTH-1:0] acc,
        input logic [DATA_WIDTH-1:0] byte_in
    );
        return acc ^ byte_in;
    endfunction

    function automatic logic parity_mismatch(
        input logic [DATA_WIDTH-1:0] computed,
        input logic [DATA_WIDTH-1:0] received
    );
        return (computed != received);
    endfunction

    logic [DATA_WIDTH-1:0] int_par_r, int_par_nxt_s;
    logic [DATA_WIDTH-1:0] pkt_par_r, pkt_par_nxt_s;
    logic                  parity_done_r, parity_done_nxt_s;
    logic                  err_r, err_nxt_s;

    // Accumulator next value; detect_add restarts it for the new packet
    always_comb begin
        int_par_nxt_s = int_par_r;
        if (detect_add) begin
            int_par_nxt_s = ZERO_BYTE;
        end else if (lfd_state) begin
            int_par_nxt_s = parity_fold(int_par_r, header);
        end else if (ld_state && pkt_valid && !fifo_full) begin
            int_par_nxt_s = parity_fold(int_par_r, data_in);
        end else if (laf_state && !hold_is_par) begin
            int_par_nxt_s = parity_fold(int_par_r, hold);
        end else begin
            int_par_nxt_s = int_par_r;
        end
    end

    // Parity byte capture, either directly or from the hold register after a full detour
    always_comb begin
        pkt_par_nxt_s     = pkt_par_r;
        parity_done_nxt_s = parity_done_r;
        if (ld_state && !pkt_valid && !fifo_full) begin
            pkt_par_nxt_s     = data_in;
            parity_done_nxt_s = 1'b1;
        end else if (laf_state && hold_is_par && !parity_done_r) begin
            pkt_par_nxt_s     = hold;
            parity_done_nxt_s = 1'b1;
        end else if (detect_add) begin
            parity_done_nxt_s = 1'b0;
        end else begin
            parity_done_nxt_s = parity_done_r;
        end
    end

    // Error flag is sticky until the next packet header is decoded
    always_comb begin
        err_nxt_s = err_r;
        if (detect_add) begin
            err_nxt_s = 1'b0;
        end else if (rst_int_reg) begin
            err_nxt_s = parity_mismatch(int_par_r, pkt_par_r);
        end else begin
            err_nxt_s = err_r;
        end
    end

    // State registers
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            int_par_r     <= ZERO_BYTE;
            pkt_par_r     <= ZERO_BYTE;
            parity_done_r <= 1'b0;
            err_r         <= 1'b0;
        end else begin
            int_par_r     <= int_par_nxt_s;
            pkt_par_r     <= pkt_par_nxt_s;
            parity_done_r <= parity_done_nxt_s;
            err_r         <= err_nxt_s;
        end
    end

    assign parity_done = parity_done_r;
    assign err         = err_r;

endmodule

// File: rtl/router_reg.sv
// Router datapath register stage: latches header and overflow bytes, drives the
// byte written into the selected output FIFO, and reports packet status to the FSM.
module router_reg import router_pkg::*; #(
    parameter int DATA_WIDTH = router_pkg::DATA_WIDTH
) (
    input  logic     clock,
    input  logic     resetn,
    router_reg_if.slave bus
);

    localparam logic [DATA_WIDTH-1:0] ZERO_BYTE = {DATA_WIDTH{1'b0}};

    logic [DATA_WIDTH-1:0] header_r;
    logic [DATA_WIDTH-1:0] hold_r;
    logic                  hold_is_par_r;
    logic [DATA_WIDTH-1:0] dout_r, dout_nxt_s;
    logic                  low_packet_valid_r, low_packet_valid_nxt_s;
    logic                  header_load_s;
    logic                  hold_load_s;
    logic                  unused_full_state_s;

    // FULL_STATE needs no datapath action; it is only observed by checkers
    assign unused_full_state_s = bus.full_state;

    // Load qualifiers; an invalid address never reaches the header register
    always_comb begin
        header_load_s = bus.detect_add & bus.pkt_valid & addr_is_valid(bus.data_in[1:0]);
        hold_load_s   = bus.ld_state & bus.fifo_full;
    end

    // Output byte select, first match wins
    always_comb begin
        dout_nxt_s = dout_r;
        if (bus.lfd_state) begin
            dout_nxt_s = header_r;
        end else if (bus.ld_state && !bus.fifo_full) begin
            dout_nxt_s = bus.data_in;
        end else if (bus.laf_state) begin
            dout_nxt_s = hold_r;
        end else begin
            dout_nxt_s = dout_r;
        end
    end

    // Clear beats set when both land in the same cycle
    always_comb begin
        low_packet_valid_nxt_s = low_packet_valid_r;
        if (bus.rst_int_reg || bus.detect_add) begin
            low_packet_valid_nxt_s = 1'b0;
        end else if (bus.ld_state && !bus.pkt_valid) begin
            low_packet_valid_nxt_s = 1'b1;
        end else begin
            low_packet_valid_nxt_s = low_packet_valid_r;
        end
    end

    // Header, hold and output registers
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            header_r           <= ZERO_BYTE;
            hold_r             <= ZERO_BYTE;
            hold_is_par_r      <= 1'b0;
            dout_r             <= ZERO_BYTE;
            low_packet_valid_r <= 1'b0;
        end else begin
            if (header_load_s) begin
                header_r <= bus.data_in;
            end
            if (hold_load_s) begin
                hold_r        <= bus.data_in;
                hold_is_par_r <= !bus.pkt_valid;
            end
            dout_r             <= dout_nxt_s;
            low_packet_valid_r <= low_packet_valid_nxt_s;
        end
    end

    router_parity_acc #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_parity_acc (
        .clock       (clock),
        .resetn      (resetn),
        .detect_add  (bus.detect_add),
        .lfd_state   (bus.lfd_state),
        .ld_state    (bus.ld_state),
        .laf_state   (bus.laf_state),
        .rst_int_reg (bus.rst_int_reg),
        .pkt_valid   (bus.pkt_valid),
        .fifo_full   (bus.fifo_full),
        .data_in     (bus.data_in),
        .header      (header_r),
        .hold        (hold_r),
        .hold_is_par (hold_is_par_r),
        .parity_done (bus.parity_done),
        .err         (bus.err)
    );

    assign bus.dout             = dout_r;
    assign bus.low_packet_valid = low_packet_valid_r;

endmodule

// File: tb/tb_router_reg.sv
// Directed bench for router_reg: drives FSM strobes as a state sequence and checks
// registered outputs one step after each rising edge against hand-computed values.
module tb_router_reg;
    import router_pkg::*;

    logic clock;
    logic resetn;
    int   checks;
    int   failures;

    router_reg_if #(.DATA_WIDTH(8)) bus ();

    router_reg #(.DATA_WIDTH(8)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    task automatic drive(input fsm_state_t st, input logic pv, input logic [7:0] din, input logic ff);
        bus.detect_add  = (st == DECODE_ADDRESS);
        bus.lfd_state   = (st == LOAD_FIRST_DATA);
        bus.ld_state    = (st == LOAD_DATA);
        bus.laf_state   = (st == LOAD_AFTER_FULL);
        bus.full_state  = (st == FIFO_FULL_STATE);
        bus.rst_int_reg = (st == CHECK_PARITY_ERROR);
        bus.pkt_valid   = pv;
        bus.data_in     = din;
        bus.fifo_full   = ff;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic step(input fsm_state_t st, input logic pv, input logic [7:0] din, input logic ff);
        drive(st, pv, din, ff);
        tick();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        resetn   = 1'b0;
        drive(WAIT_TILL_EMPTY, 1'b0, 8'h00, 1'b0);
        #23;
        chk("rst_dout", bus.dout, 8'h00);
        chk("rst_pd", {7'd0, bus.parity_done}, 8'h00);
        chk("rst_lpv", {7'd0, bus.low_packet_valid}, 8'h00);
        chk("rst_err", {7'd0, bus.err}, 8'h00);
        resetn = 1'b1;
        tick();

        // 1: normal packet 0D / 11 22 33 / parity 0D
        step(DECODE_ADDRESS, 1'b1, 8'h0D, 1'b0);
        chk("p1_dec_dout", bus.dout, 8'h00);
        step(LOAD_FIRST_DATA, 1'b1, 8'h11, 1'b0);
        chk("p1_lfd_dout", bus.dout, 8'h0D);
        step(LOAD_DATA, 1'b1, 8'h11, 1'b0);
        chk("p1_d0", bus.dout, 8'h11);
        step(LOAD_DATA, 1'b1, 8'h22, 1'b0);
        chk("p1_d1", bus.dout, 8'h22);
        step(LOAD_DATA, 1'b1, 8'h33, 1'b0);
        chk("p1_d2", bus.dout, 8'h33);
        chk("p1_pd_early", {7'd0, bus.parity_done}, 8'h00);
        step(LOAD_DATA, 1'b0, 8'h0D, 1'b0);
        chk("p1_par_dout", bus.dout, 8'h0D);
        chk("p1_pd", {7'd0, bus.parity_done}, 8'h01);
        chk("p1_lpv", {7'd0, bus.low_packet_valid}, 8'h01);
        step(LOAD_PARITY, 1'b0, 8'h00, 1'b0);
        chk("p1_lp_hold", bus.dout, 8'h0D);
        step(CHECK_PARITY_ERROR, 1'b0, 8'h00, 1'b0);
        chk("p1_err", {7'd0, bus.err}, 8'h00);
        chk("p1_lpv_clr", {7'd0, bus.low_packet_valid}, 8'h00);

        // 2: same packet, corrupt parity byte
        step(DECODE_ADDRESS, 1'b1, 8'h0D, 1'b0);
        chk("p2_pd_clr", {7'd0, bus.parity_done}, 8'h00);
        step(LOAD_FIRST_DATA, 1'b1, 8'h11, 1'b0);
        step(LOAD_DATA, 1'b1, 8'h11, 1'b0);
        step(LOAD_DATA, 1'b1, 8'h22, 1'b0);
        step(LOAD_DATA, 1'b1, 8'h33, 1'b0);
        step(LOAD_DATA, 1'b0, 8'h00, 1'b0);
        chk("p2_par_dout", bus.dout, 8'h00);
        step(LOAD_PARITY, 1'b0, 8'h00, 1'b0);
        chk("p2_err_pre", {7'd0, bus.err}, 8'h00);
        step(CHECK_PARITY_ERROR, 1'b0, 8'h00, 1'b0);
        chk("p2_err", {7'd0, bus.err}, 8'h01);
        step(FIFO_FULL_STATE, 1'b0, 8'h00, 1'b1);
        chk("p2_err_sticky", {7'd0, bus.err}, 8'h01);

        // 3: FIFO fills while payload byte 22 arrives
        step(DECODE_ADDRESS, 1'b1, 8'h0D, 1'b0);
        chk("p3_err_clr", {7'd0, bus.err}, 8'h00);
        step(LOAD_FIRST_DATA, 1'b1, 8'h11, 1'b0);
        step(LOAD_DATA, 1'b1, 8'h11, 1'b0);
        step(LOAD_DATA, 1'b1, 8'h22, 1'b1);
        chk("p3_full_dout", bus.dout, 8'h11);
        step(FIFO_FULL_STATE, 1'b1, 8'h33, 1'b1);
        step(FIFO_FULL_STATE, 1'b1, 8'h33, 1'b1);
        step(FIFO_FULL_STATE, 1'b1, 8'h33, 1'b0);
        chk("p3_ffs_dout", bus.dout, 8'h11);
        step(LOAD_AFTER_FULL, 1'b1, 8'h33, 1'b0);
        chk("p3_laf_dout", bus.dout, 8'h22);
        chk("p3_laf_pd", {7'd0, bus.parity_done}, 8'h00);
        step(LOAD_DATA, 1'b1, 8'h33, 1'b0);
        chk("p3_d2", bus.dout, 8'h33);
        step(LOAD_DATA, 1'b0, 8'h0D, 1'b0);
        chk("p3_pd", {7'd0, bus.parity_done}, 8'h01);
        step(LOAD_PARITY, 1'b0, 8'h00, 1'b0);
        step(CHECK_PARITY_ERROR, 1'b0, 8'h00, 1'b0);
        chk("p3_err", {7'd0, bus.err}, 8'h00);

        // 4: FIFO fills on the parity byte
        step(DECODE_ADDRESS, 1'b1, 8'h0D, 1'b0);
        step(LOAD_FIRST_DATA, 1'b1, 8'h11, 1'b0);
        step(LOAD_DATA, 1'b1, 8'h11, 1'b0);
        step(LOAD_DATA, 1'b1, 8'h22, 1'b0);
        step(LOAD_DATA, 1'b1, 8'h33, 1'b0);
        step(LOAD_DATA, 1'b0, 8'h0D, 1'b1);
        chk("p4_lpv", {7'd0, bus.low_packet_valid}, 8'h01);
        chk("p4_pd_wait", {7'd0, bus.parity_done}, 8'h00);
        chk("p4_full_dout", bus.dout, 8'h33);
        step(FIFO_FULL_STATE, 1'b0, 8'h00, 1'b0);
        step(LOAD_AFTER_FULL, 1'b0, 8'h00, 1'b0);
        chk("p4_laf_pd", {7'd0, bus.parity_done}, 8'h01);
        chk("p4_laf_dout", bus.dout, 8'h0D);
        chk("p4_laf_lpv", {7'd0, bus.low_packet_valid}, 8'h01);
        step(CHECK_PARITY_ERROR, 1'b0, 8'h00, 1'b0);
        chk("p4_err", {7'd0, bus.err}, 8'h00);
        chk("p4_lpv_clr", {7'd0, bus.low_packet_valid}, 8'h00);

        // 5: invalid address and pkt_valid-low headers are not latched
        step(DECODE_ADDRESS, 1'b1, 8'h06, 1'b0);
        step(DECODE_ADDRESS, 1'b1, 8'h07, 1'b0);
        chk("p5_inv_dout", bus.dout, 8'h0D);
        step(DECODE_ADDRESS, 1'b0, 8'h09, 1'b0);
        step(LOAD_FIRST_DATA, 1'b1, 8'h11, 1'b0);
        chk("p5_header", bus.dout, 8'h06);

        // 6: asynchronous reset mid-payload
        step(LOAD_DATA, 1'b1, 8'h11, 1'b0);
        step(LOAD_DATA, 1'b0, 8'h55, 1'b1);
        chk("p6_lpv_pre", {7'd0, bus.low_packet_valid}, 8'h01);
        #2;
        resetn = 1'b0;
        #1;
        chk("p6_rst_dout", bus.dout, 8'h00);
        chk("p6_rst_lpv", {7'd0, bus.low_packet_valid}, 8'h00);
        chk("p6_rst_pd", {7'd0, bus.parity_done}, 8'h00);
        chk("p6_rst_err", {7'd0, bus.err}, 8'h00);
        drive(WAIT_TILL_EMPTY, 1'b0, 8'h00, 1'b0);
        #3;
        resetn = 1'b1;
        tick();
        step(DECODE_ADDRESS, 1'b1, 8'h0E, 1'b0);
        step(LOAD_FIRST_DATA, 1'b1, 8'hA5, 1'b0);
        chk("p6_lfd", bus.dout, 8'h0E);
        step(LOAD_DATA, 1'b1, 8'hA5, 1'b0);
        step(LOAD_DATA, 1'b1, 8'h3C, 1'b0);
        step(LOAD_DATA, 1'b1, 8'hF0, 1'b0);
        step(LOAD_DATA, 1'b0, 8'h67, 1'b0);
        chk("p6_par_dout", bus.dout, 8'h67);
        step(LOAD_PARITY, 1'b0, 8'h00, 1'b0);
        step(CHECK_PARITY_ERROR, 1'b0, 8'h00, 1'b0);
        chk("p6_err", {7'd0, bus.err}, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
